// File: rtl/fpu_package.sv
// Shared fixed-point unit definitions: operand widths and divider state/iteration constants.
package fpu_package;

  parameter int INPUT_WIDTH  = 32;
  parameter int OUTPUT_WIDTH = 40;

  typedef enum logic [1:0] {DIV_IDLE, DIV_CALC, DIV_DONE} div_state_t;

  parameter int DIV_ITER  = INPUT_WIDTH;
  parameter int DIV_CNT_W = $clog2(DIV_ITER) + 1;

endpackage

// File: rtl/fpu_div_step.sv
// One restoring-division iteration: trial-subtract the divisor from {partial remainder, next bit}.
module fpu_div_step #(
  parameter int WIDTH = 32
) (
  input  logic [WIDTH:0]   trial,
  input  logic [WIDTH-1:0] divisor,
  output logic [WIDTH-1:0] rem_out,
  output logic             q_bit
);

  logic [WIDTH:0] diff;

  // Partial remainder is always below the divisor, so diff MSB is a pure borrow flag.
  always_comb begin
    diff    = trial - {1'b0, divisor};
    q_bit   = ~diff[WIDTH];
    rem_out = q_bit ? diff[WIDTH-1:0] : trial[WIDTH-1:0];
  end

endmodule

// File: rtl/fpu_div_seq.sv
// Sequential radix-2 restoring divider: one quotient bit per cycle, sign handling on magnitudes.
module fpu_div_seq #(
  parameter int INPUT_WIDTH  = fpu_package::INPUT_WIDTH,
  parameter int OUTPUT_WIDTH = fpu_package::OUTPUT_WIDTH
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    in_valid,
  output logic                    in_ready,
  input  logic [INPUT_WIDTH-1:0]  dividend,
  input  logic [INPUT_WIDTH-1:0]  divisor,
  input  logic                    is_signed,
  output logic                    out_valid,
  input  logic                    out_ready,
  output logic [OUTPUT_WIDTH-1:0] quotient,
  output logic [INPUT_WIDTH-1:0]  remainder,
  output logic                    div_by_zero
);
  import fpu_package::*;

  localparam int W     = INPUT_WIDTH;
  localparam int OW    = OUTPUT_WIDTH;
  localparam int CNT_W = $clog2(W) + 1;

  div_state_t      state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [W-1:0]    rem_q, rem_d;
  logic [W-1:0]    dvd_q, dvd_d;
  logic [W-1:0]    dvs_q, dvs_d;
  logic            neg_q_q, neg_q_d;
  logic            neg_r_q, neg_r_d;
  logic            in_ready_q, in_ready_d;
  logic            out_valid_q, out_valid_d;
  logic [OW-1:0]   quotient_q, quotient_d;
  logic [W-1:0]    remainder_q, remainder_d;
  logic            dbz_q, dbz_d;

  logic            a_neg, b_neg;
  logic [W-1:0]    dvd_mag, dvs_mag;
  logic [W-1:0]    step_rem;
  logic            step_q;
  logic [W-1:0]    q_mag;
  logic [OW-1:0]   q_ext;

  fpu_div_step #(.WIDTH(W)) u_step (
    .trial   ({rem_q, dvd_q[W-1]}),
    .divisor (dvs_q),
    .rem_out (step_rem),
    .q_bit   (step_q)
  );

  always_comb begin
    a_neg   = is_signed & dividend[W-1];
    b_neg   = is_signed & divisor[W-1];
    dvd_mag = a_neg ? -dividend : dividend;
    dvs_mag = b_neg ? -divisor : divisor;
    // The dividend register doubles as the quotient shift register.
    q_mag   = {dvd_q[W-2:0], step_q};
    q_ext   = OW'(q_mag);
  end

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    rem_d       = rem_q;
    dvd_d       = dvd_q;
    dvs_d       = dvs_q;
    neg_q_d     = neg_q_q;
    neg_r_d     = neg_r_q;
    in_ready_d  = in_ready_q;
    out_valid_d = out_valid_q;
    quotient_d  = quotient_q;
    remainder_d = remainder_q;
    dbz_d       = dbz_q;
    case (state_q)
      DIV_IDLE: begin
        if (in_valid) begin
          neg_q_d    = a_neg ^ b_neg;
          neg_r_d    = a_neg;
          dvd_d      = dvd_mag;
          dvs_d      = dvs_mag;
          rem_d      = '0;
          cnt_d      = '0;
          in_ready_d = 1'b0;
          if (divisor == '0) begin
            state_d     = DIV_DONE;
            out_valid_d = 1'b1;
            quotient_d  = '1;
            remainder_d = dividend;
            dbz_d       = 1'b1;
          end else begin
            state_d = DIV_CALC;
          end
        end
      end
      DIV_CALC: begin
        rem_d = step_rem;
        dvd_d = q_mag;
        cnt_d = cnt_q + 1'b1;
        if (cnt_q == CNT_W'(W - 1)) begin
          state_d     = DIV_DONE;
          out_valid_d = 1'b1;
          quotient_d  = neg_q_q ? -q_ext : q_ext;
          remainder_d = neg_r_q ? -step_rem : step_rem;
          dbz_d       = 1'b0;
        end
      end
      DIV_DONE: begin
        if (out_ready) begin
          state_d     = DIV_IDLE;
          out_valid_d = 1'b0;
          in_ready_d  = 1'b1;
          cnt_d       = '0;
        end
      end
      default: begin
        state_d     = DIV_IDLE;
        out_valid_d = 1'b0;
        in_ready_d  = 1'b1;
        cnt_d       = '0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= DIV_IDLE;
      cnt_q       <= '0;
      rem_q       <= '0;
      dvd_q       <= '0;
      dvs_q       <= '0;
      neg_q_q     <= 1'b0;
      neg_r_q     <= 1'b0;
      in_ready_q  <= 1'b1;
      out_valid_q <= 1'b0;
      quotient_q  <= '0;
      remainder_q <= '0;
      dbz_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      rem_q       <= rem_d;
      dvd_q       <= dvd_d;
      dvs_q       <= dvs_d;
      neg_q_q     <= neg_q_d;
      neg_r_q     <= neg_r_d;
      in_ready_q  <= in_ready_d;
      out_valid_q <= out_valid_d;
      quotient_q  <= quotient_d;
      remainder_q <= remainder_d;
      dbz_q       <= dbz_d;
    end
  end

  assign in_ready    = in_ready_q;
  assign out_valid   = out_valid_q;
  assign quotient    = quotient_q;
  assign remainder   = remainder_q;
  assign div_by_zero = dbz_q;

endmodule

// File: tb/tb_fpu_div_seq.sv
// Directed bench for fpu_div_seq: hand-computed quotients/remainders, latency, backpressure, reset.
module tb_fpu_div_seq;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] dividend;
  logic [31:0] divisor;
  logic        is_signed;
  logic        out_valid;
  logic        out_ready;
  logic [39:0] quotient;
  logic [31:0] remainder;
  logic        div_by_zero;

  int n_chk  = 0;
  int n_fail = 0;

  always #5 clk = ~clk;

  fpu_div_seq #(.INPUT_WIDTH(32), .OUTPUT_WIDTH(40)) dut (
    .clk         (clk),
    .rst         (rst),
    .in_valid    (in_valid),
    .in_ready    (in_ready),
    .dividend    (dividend),
    .divisor     (divisor),
    .is_signed   (is_signed),
    .out_valid   (out_valid),
    .out_ready   (out_ready),
    .quotient    (quotient),
    .remainder   (remainder),
    .div_by_zero (div_by_zero)
  );

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Counts edges after the accept edge until out_valid, then checks the result fields.
  task automatic wait_result(input string tag, input int exp_lat, input logic [39:0] exp_q,
                             input logic [31:0] exp_r, input logic exp_dbz);
    int lat = 0;
    while (!out_valid && lat < 100) begin
      tick();
      lat++;
    end
    chk({tag, " latency"}, 64'(lat), 64'(exp_lat));
    chk({tag, " quotient"}, 64'(quotient), 64'(exp_q));
    chk({tag, " remainder"}, 64'(remainder), 64'(exp_r));
    chk({tag, " div_by_zero"}, 64'(div_by_zero), 64'(exp_dbz));
  endtask

  task automatic accept(input string tag, input logic [31:0] a, input logic [31:0] b, input logic sgn);
    chk({tag, " in_ready before accept"}, 64'(in_ready), 64'd1);
    dividend  = a;
    divisor   = b;
    is_signed = sgn;
    in_valid  = 1'b1;
    tick();
    in_valid  = 1'b0;
    dividend  = 32'hDEAD_BEEF;
    divisor   = 32'h0000_0003;
    chk({tag, " in_ready after accept"}, 64'(in_ready), 64'd0);
  endtask

  task automatic do_div(input string tag, input logic [31:0] a, input logic [31:0] b, input logic sgn,
                        input int exp_lat, input logic [39:0] exp_q, input logic [31:0] exp_r,
                        input logic exp_dbz);
    accept(tag, a, b, sgn);
    wait_result(tag, exp_lat, exp_q, exp_r, exp_dbz);
    tick();
    chk({tag, " idle out_valid"}, 64'(out_valid), 64'd0);
    chk({tag, " idle in_ready"}, 64'(in_ready), 64'd1);
  endtask

  initial begin
    int seen;
    rst       = 1'b1;
    in_valid  = 1'b0;
    dividend  = '0;
    divisor   = '0;
    is_signed = 1'b0;
    out_ready = 1'b1;
    tick();
    tick();
    rst = 1'b0;
    chk("reset in_ready", 64'(in_ready), 64'd1);
    chk("reset out_valid", 64'(out_valid), 64'd0);
    chk("reset quotient", 64'(quotient), 64'd0);
    chk("reset remainder", 64'(remainder), 64'd0);
    chk("reset div_by_zero", 64'(div_by_zero), 64'd0);

    do_div("s 100/7",      32'd100,       32'd7,         1'b1, 32, 40'h00_0000_000E, 32'h0000_0002, 1'b0);
    do_div("s -100/7",     32'hFFFF_FF9C, 32'd7,         1'b1, 32, 40'hFF_FFFF_FFF2, 32'hFFFF_FFFE, 1'b0);
    do_div("s min/-1",     32'h8000_0000, 32'hFFFF_FFFF, 1'b1, 32, 40'h00_8000_0000, 32'h0000_0000, 1'b0);
    do_div("u max/1",      32'hFFFF_FFFF, 32'd1,         1'b0, 32, 40'h00_FFFF_FFFF, 32'h0000_0000, 1'b0);
    do_div("s -1/1",       32'hFFFF_FFFF, 32'd1,         1'b1, 32, 40'hFF_FFFF_FFFF, 32'h0000_0000, 1'b0);
    do_div("s 7/-2",       32'd7,         32'hFFFF_FFFE, 1'b1, 32, 40'hFF_FFFF_FFFD, 32'h0000_0001, 1'b0);
    do_div("s -7/-2",      32'hFFFF_FFF9, 32'hFFFF_FFFE, 1'b1, 32, 40'h00_0000_0003, 32'hFFFF_FFFF, 1'b0);
    do_div("u 7/100",      32'd7,         32'd100,       1'b0, 32, 40'h00_0000_0000, 32'h0000_0007, 1'b0);
    do_div("u max/max",    32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0, 32, 40'h00_0000_0001, 32'h0000_0000, 1'b0);
    do_div("u dbz",        32'h1234_5678, 32'd0,         1'b0, 0,  40'hFF_FFFF_FFFF, 32'h1234_5678, 1'b1);
    do_div("u after dbz",  32'd1000,      32'd10,        1'b0, 32, 40'h00_0000_0064, 32'h0000_0000, 1'b0);
    do_div("s dbz neg",    32'h8000_0000, 32'd0,         1'b1, 0,  40'hFF_FFFF_FFFF, 32'h8000_0000, 1'b1);
    do_div("s after dbz",  32'd100,       32'd7,         1'b1, 32, 40'h00_0000_000E, 32'h0000_0002, 1'b0);

    // Backpressure: result held in DONE while new operands wait at the input.
    out_ready = 1'b0;
    accept("bp", 32'd100, 32'd7, 1'b1);
    wait_result("bp", 32, 40'h00_0000_000E, 32'h0000_0002, 1'b0);
    dividend  = 32'd1000;
    divisor   = 32'd10;
    is_signed = 1'b0;
    in_valid  = 1'b1;
    for (int i = 0; i < 10; i++) begin
      tick();
      chk("bp hold out_valid", 64'(out_valid), 64'd1);
      chk("bp hold in_ready", 64'(in_ready), 64'd0);
      chk("bp hold quotient", 64'(quotient), 64'h00_0000_000E);
      chk("bp hold remainder", 64'(remainder), 64'h0000_0002);
    end
    out_ready = 1'b1;
    tick();
    chk("bp release out_valid", 64'(out_valid), 64'd0);
    chk("bp release in_ready", 64'(in_ready), 64'd1);
    tick();
    in_valid = 1'b0;
    chk("bp next accepted", 64'(in_ready), 64'd0);
    wait_result("bp next", 32, 40'h00_0000_0064, 32'h0000_0000, 1'b0);
    tick();

    // Reset in the middle of CALC, with iteration 15 about to execute.
    accept("rst", 32'd100, 32'd7, 1'b1);
    repeat (15) tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk("rst in_ready", 64'(in_ready), 64'd1);
    chk("rst out_valid", 64'(out_valid), 64'd0);
    seen = 0;
    for (int i = 0; i < 40; i++) begin
      tick();
      if (out_valid) seen++;
    end
    chk("rst out_valid never rose", 64'(seen), 64'd0);
    do_div("rst fresh", 32'd100, 32'd7, 1'b1, 32, 40'h00_0000_000E, 32'h0000_0002, 1'b0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
